// File: rtl/vga_pixel_queue.sv
// Pixel-command queue in front of the VGA control stage; streams queued words and expands clear commands into a 160x120 sweep.
// Latency: a word pushed into an empty queue is presented on pix_word one edge later; a clear yields 19200 words starting one edge after its pop.
// Backpressure: none toward the CPU; writes while full are dropped and flagged in the sticky overflow bit.

module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   level,
    output logic [AW:0]   level_nxt,
    output logic          full
);
    // Generic single-clock FIFO.
    // Latency: head_dat reflects a pushed word on the edge after the push.
    // Backpressure: caller must not push when full or pop when empty.

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head_dat = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_nxt;
            full  <= (level_nxt == FULL_LVL);
        end
    end
endmodule

module vga_pixel_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [31:0]   wr_data,
    input  logic          ovf_clr,
    output logic [31:0]   pix_word,
    output logic [AW:0]   level,
    output logic          full,
    output logic          busy,
    output logic          overflow
);
    localparam logic [31:0] IDLE_WORD = 32'h7F00_0000;
    localparam logic [7:0]  X_LAST    = 8'd159;
    localparam logic [6:0]  Y_LAST    = 7'd119;

    typedef enum logic {STREAM, FILL} state_t;

    state_t      state;
    logic [7:0]  fx;
    logic [6:0]  fy;
    logic [7:0]  fcol;
    logic        push;
    logic        pop;
    logic        fill_nxt;
    logic [31:0] head_dat;
    logic [AW:0] level_nxt;

    // full is the registered flag, so a same-edge pop never makes room for a write.
    assign push = wr_en && !full;
    assign pop  = (state == STREAM) && (level != '0);

    always_comb begin
        fill_nxt = 1'b0;
        if (state == STREAM) begin
            fill_nxt = pop && head_dat[31];
        end else begin
            fill_nxt = !((fx == X_LAST) && (fy == Y_LAST));
        end
    end

    fifo #(
        .W     (32),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_dat  (wr_data),
        .pop       (pop),
        .head_dat  (head_dat),
        .level     (level),
        .level_nxt (level_nxt),
        .full      (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STREAM;
            fx       <= '0;
            fy       <= '0;
            fcol     <= '0;
            pix_word <= IDLE_WORD;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy <= fill_nxt || (level_nxt != '0);

            if (ovf_clr) begin
                overflow <= 1'b0;
            end else if (wr_en && full) begin
                overflow <= 1'b1;
            end

            case (state)
                STREAM: begin
                    if (!pop) begin
                        pix_word <= IDLE_WORD;
                    end else if (head_dat[31]) begin
                        // The clear pop itself presents (0,0); the sweep continues from x=1.
                        fcol     <= head_dat[7:0];
                        pix_word <= {1'b0, 7'd0, 8'd0, 8'h00, head_dat[7:0]};
                        fx       <= 8'd1;
                        fy       <= 7'd0;
                        state    <= FILL;
                    end else begin
                        pix_word <= {1'b0, head_dat[30:0]};
                    end
                end
                FILL: begin
                    pix_word <= {1'b0, fy, fx, 8'h00, fcol};
                    if (fx == X_LAST) begin
                        fx <= 8'd0;
                        if (fy == Y_LAST) begin
                            state <= STREAM;
                        end else begin
                            fy <= fy + 1'b1;
                        end
                    end else begin
                        fx <= fx + 1'b1;
                    end
                end
                default: state <= STREAM;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_pixel_queue.sv
// Randomized bench for vga_pixel_queue against a queue-and-index reference model.
module tb_vga_pixel_queue;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [31:0] IDLE_WORD = 32'h7F00_0000;
    localparam int NPIX  = 19200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        ovf_clr = 1'b0;
    logic [31:0] pix_word;
    logic [AW:0] level;
    logic        full;
    logic        busy;
    logic        overflow;

    vga_pixel_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .pix_word (pix_word),
        .level    (level),
        .full     (full),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending words, and index of the next sweep pixel (-1 when not sweeping).
    logic [31:0] q[$];
    int          fill_idx = -1;
    logic [7:0]  m_col = '0;
    logic [31:0] m_pix = IDLE_WORD;
    logic        m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pixel(input int x, input int y, input logic [7:0] c);
        return (32'(y) << 24) | (32'(x) << 16) | 32'(c);
    endfunction

    function automatic logic [31:0] rand_pix();
        return $urandom & 32'h7FFF_FFFF;
    endfunction

    task automatic model_reset();
        q.delete();
        fill_idx = -1;
        m_pix    = IDLE_WORD;
        m_ovf    = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [31:0] wd, input logic oc);
        bit          full_pre;
        logic [31:0] w;
        full_pre = (q.size() == DEPTH);
        if (fill_idx >= 0) begin
            m_pix = pixel(fill_idx % 160, fill_idx / 160, m_col);
            fill_idx++;
            if (fill_idx == NPIX) fill_idx = -1;
        end else if (q.size() > 0) begin
            w = q.pop_front();
            if (w[31]) begin
                m_col    = w[7:0];
                m_pix    = pixel(0, 0, m_col);
                fill_idx = 1;
            end else begin
                m_pix = {1'b0, w[30:0]};
            end
        end else begin
            m_pix = IDLE_WORD;
        end
        if (we && !full_pre) q.push_back(wd);
        if (oc) m_ovf = 1'b0;
        else if (we && full_pre) m_ovf = 1'b1;
    endtask

    task automatic check_all();
        chk("pix_word", pix_word, m_pix);
        chk("level", 32'(level), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("busy", 32'(busy), 32'((fill_idx >= 0) || (q.size() > 0)));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic cyc(input logic we, input logic [31:0] wd, input logic oc);
        wr_en   = we;
        wr_data = wd;
        ovf_clr = oc;
        @(posedge clk);
        model_edge(we, wd, oc);
        #1;
        check_all();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (((fill_idx >= 0) || (q.size() > 0)) && (n < max_cycles)) begin
            cyc(1'b0, '0, 1'b0);
            n++;
        end
        chk("drain_timeout", 32'(n < max_cycles), 32'd1);
    endtask

    initial begin
        logic [31:0] px;
        int          n;
        bit          reached;

        // Reset and idle
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #20 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0);
        chk("idle_pix", pix_word, IDLE_WORD);

        // Single write
        cyc(1'b1, 32'h0A32_0005, 1'b0);
        chk("single_lvl1", 32'(level), 32'd1);
        cyc(1'b0, '0, 1'b0);
        chk("single_pix", pix_word, 32'h0A32_0005);
        chk("single_lvl0", 32'(level), 32'd0);
        cyc(1'b0, '0, 1'b0);
        chk("single_idle", pix_word, IDLE_WORD);

        // Clear holds off the drain; 17 writes overflow by one
        cyc(1'b1, 32'h8000_0005, 1'b0);
        for (int i = 0; i < 17; i++) cyc(1'b1, rand_pix(), 1'b0);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_set", 32'(overflow), 32'd1);
        cyc(1'b0, '0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);
        drain(NPIX + 100);

        // Full sweep with colour 3, one pixel queued mid-fill
        cyc(1'b1, 32'h8000_0003, 1'b0);
        reached = 0;
        for (int i = 0; i < NPIX + 40; i++) begin
            if (i == 5000) cyc(1'b1, 32'h0511_00AA, 1'b0);
            else cyc(1'b0, '0, 1'b0);
            if (pixel(159, 0, 8'd3) == m_pix) begin
                cyc(1'b0, '0, 1'b0);
                chk("wrap_x159_y0", pix_word, pixel(0, 1, 8'd3));
            end
            if (pixel(159, 119, 8'd3) == m_pix) begin
                reached = 1;
                cyc(1'b0, '0, 1'b0);
                chk("after_fill", pix_word, 32'h0511_00AA);
                break;
            end
        end
        chk("fill_end_seen", 32'(reached), 32'd1);
        drain(100);

        // Reset in the middle of a sweep with 3 words pending
        cyc(1'b1, 32'h8000_0042, 1'b0);
        reached = 0;
        n = 0;
        for (int i = 0; i < 4000; i++) begin
            if (n < 3 && (i % 100) == 99) begin
                cyc(1'b1, rand_pix(), 1'b0);
                n++;
            end else begin
                cyc(1'b0, '0, 1'b0);
            end
            if (m_pix == pixel(40, 20, 8'h42)) begin
                reached = 1;
                break;
            end
        end
        chk("mid_fill_reached", 32'(reached), 32'd1);
        chk("mid_fill_lvl", 32'(level), 32'd3);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_pix", pix_word, IDLE_WORD);
        chk("rst_lvl", 32'(level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        check_all();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0);

        // Continuous writes keep level at 1 and wrap the pointers
        for (int i = 0; i < 50; i++) begin
            cyc(1'b1, rand_pix(), 1'b0);
            chk("steady_lvl", 32'(level), 32'd1);
        end
        chk("steady_ovf", 32'(overflow), 32'd0);
        drain(10);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            px = rand_pix();
            cyc(1'($urandom_range(0, 3) != 0), px, 1'($urandom_range(0, 15) == 0));
        end
        drain(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
